// File: rtl/pipe_mem_pkg.sv
// Shared definitions for the MEM stage: load-type codes, pipeline bus layouts, exception codes.
package pipe_mem_pkg;

    localparam int unsigned LOAD_OP_BITS = 3;

    localparam logic [LOAD_OP_BITS-1:0] LD_NONE = 3'd0;
    localparam logic [LOAD_OP_BITS-1:0] LD_B    = 3'd1;
    localparam logic [LOAD_OP_BITS-1:0] LD_H    = 3'd2;
    localparam logic [LOAD_OP_BITS-1:0] LD_W    = 3'd3;
    localparam logic [LOAD_OP_BITS-1:0] LD_BU   = 3'd4;
    localparam logic [LOAD_OP_BITS-1:0] LD_HU   = 3'd5;

    // exc bus: {exception_source[5:0], bad_vaddr[31:0]}
    localparam int unsigned EXC_BUS_W    = 38;
    localparam int unsigned EXC_SRC_MSB  = 37;
    localparam int unsigned EXC_SRC_LSB  = 32;
    localparam int unsigned EXC_BADV_MSB = 31;

    // csr bus: {csr_num[13:0], csr_en, csr_we, wmask[31:0], wdata[31:0], ertn}
    localparam int unsigned CSR_BUS_W     = 81;
    localparam int unsigned CSR_NUM_LSB   = 67;
    localparam int unsigned CSR_EN_BIT    = 66;
    localparam int unsigned CSR_WE_BIT    = 65;
    localparam int unsigned CSR_WMASK_LSB = 33;
    localparam int unsigned CSR_WDATA_LSB = 1;
    localparam int unsigned CSR_ERTN_BIT  = 0;

    // tlb bus: {tlbcommand[2:0], tlb_flush}
    localparam int unsigned TLB_BUS_W     = 4;
    localparam int unsigned TLB_CMD_LSB   = 1;
    localparam int unsigned TLB_FLUSH_BIT = 0;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_PIL  = 6'h01;
    localparam logic [5:0] ECODE_PIS  = 6'h02;
    localparam logic [5:0] ECODE_PIF  = 6'h03;
    localparam logic [5:0] ECODE_PME  = 6'h04;
    localparam logic [5:0] ECODE_PPI  = 6'h07;
    localparam logic [5:0] ECODE_ADE  = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0b;
    localparam logic [5:0] ECODE_BRK  = 6'h0c;
    localparam logic [5:0] ECODE_INE  = 6'h0d;
    localparam logic [5:0] ECODE_IPE  = 6'h0e;
    localparam logic [5:0] ECODE_TLBR = 6'h3f;

endpackage

// File: rtl/pipe_mem_load_align.sv
// Selects the addressed byte/half of a load word and sign- or zero-extends it.
module pipe_mem_load_align
    import pipe_mem_pkg::*;
#(
    parameter int unsigned LOAD_OP_W = 3
) (
    input  logic [1:0]           addr,
    input  logic [LOAD_OP_W-1:0] load_op,
    input  logic [31:0]          rdata,
    output logic [31:0]          result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        unique case (addr)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        result = rdata;
        case (load_op)
            LOAD_OP_W'(LD_B):  result = {{24{byte_lane[7]}}, byte_lane};
            LOAD_OP_W'(LD_BU): result = {24'd0, byte_lane};
            LOAD_OP_W'(LD_H):  result = {{16{half_lane[15]}}, half_lane};
            LOAD_OP_W'(LD_HU): result = {16'd0, half_lane};
            default:           result = rdata;
        endcase
    end

endmodule

// File: rtl/pipe_mem.sv
// MEM pipeline stage: latches EX results, waits for the data-SRAM response, aligns load data
// and forwards results to WB; discards responses belonging to flushed requests.
module pipe_mem
    import pipe_mem_pkg::*;
#(
    parameter int unsigned LOAD_OP_W = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 from_valid,
    input  logic [31:0]          from_pc,
    output logic                 to_allowin,
    output logic                 to_valid,
    input  logic                 from_allowin,
    input  logic                 flush,
    input  logic                 rf_we_EX,
    input  logic [4:0]           rf_waddr_EX,
    input  logic [31:0]          alu_result_EX,
    input  logic [LOAD_OP_W-1:0] load_op_EX,
    input  logic                 mem_req_EX,
    input  logic [EXC_BUS_W-1:0] exc_bus_EX,
    input  logic [CSR_BUS_W-1:0] csr_bus_EX,
    input  logic [TLB_BUS_W-1:0] tlb_bus_EX,
    input  logic                 data_sram_data_ok,
    input  logic [31:0]          data_sram_rdata,
    output logic [31:0]          PC,
    output logic                 rf_we_MEM,
    output logic [4:0]           rf_waddr_MEM,
    output logic [31:0]          rf_wdata_MEM,
    output logic [EXC_BUS_W-1:0] exc_bus_MEM,
    output logic [CSR_BUS_W-1:0] csr_bus_MEM,
    output logic [TLB_BUS_W-1:0] tlb_bus_MEM,
    output logic                 fwd_we,
    output logic                 load_pending
);

    logic                 valid_q;
    logic [31:0]          pc_q;
    logic                 rf_we_q;
    logic [4:0]           rf_waddr_q;
    logic [31:0]          alu_result_q;
    logic [LOAD_OP_W-1:0] load_op_q;
    logic [EXC_BUS_W-1:0] exc_bus_q;
    logic [CSR_BUS_W-1:0] csr_bus_q;
    logic [TLB_BUS_W-1:0] tlb_bus_q;
    logic                 req_out_q, req_out_d;
    logic [1:0]           drop_cnt_q, drop_cnt_d;
    logic [31:0]          data_buf_q;
    logic                 data_buf_v_q, data_buf_v_d;

    logic        accept, advance, ready_go, is_load;
    logic        ok_mine, drop_inc, drop_dec;
    logic [31:0] load_data, load_result;

    // A response only belongs to this stage once all dropped responses have drained.
    assign ok_mine  = data_sram_data_ok & (drop_cnt_q == 2'd0);
    assign ready_go = ~req_out_q | ok_mine | data_buf_v_q;
    assign is_load  = load_op_q != LOAD_OP_W'(LD_NONE);

    assign to_allowin   = ~valid_q | (ready_go & from_allowin);
    assign to_valid     = valid_q & ready_go & ~flush;
    assign accept       = from_valid & to_allowin;
    assign advance      = valid_q & ready_go & from_allowin;
    assign fwd_we       = valid_q & rf_we_q;
    assign load_pending = valid_q & is_load & ~ready_go;

    assign drop_inc = flush & req_out_q & ~ok_mine;
    assign drop_dec = data_sram_data_ok & (drop_cnt_q != 2'd0);

    always_comb begin
        req_out_d = req_out_q;
        if (flush) begin
            req_out_d = 1'b0;
        end else if (accept) begin
            req_out_d = mem_req_EX;
        end else if (ok_mine) begin
            req_out_d = 1'b0;
        end
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_inc && !drop_dec) begin
            drop_cnt_d = (drop_cnt_q == 2'd2) ? 2'd2 : drop_cnt_q + 2'd1;
        end else if (drop_dec && !drop_inc) begin
            drop_cnt_d = drop_cnt_q - 2'd1;
        end
    end

    always_comb begin
        data_buf_v_d = data_buf_v_q;
        if (flush || advance) begin
            data_buf_v_d = 1'b0;
        end else if (req_out_q && ok_mine) begin
            data_buf_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= 1'b0;
            pc_q         <= '0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            alu_result_q <= '0;
            load_op_q    <= '0;
            exc_bus_q    <= '0;
            csr_bus_q    <= '0;
            tlb_bus_q    <= '0;
            req_out_q    <= 1'b0;
            drop_cnt_q   <= '0;
            data_buf_q   <= '0;
            data_buf_v_q <= 1'b0;
        end else begin
            if (flush) begin
                valid_q <= 1'b0;
            end else if (to_allowin) begin
                valid_q <= from_valid;
            end
            if (accept) begin
                pc_q         <= from_pc;
                rf_we_q      <= rf_we_EX;
                rf_waddr_q   <= rf_waddr_EX;
                alu_result_q <= alu_result_EX;
                load_op_q    <= load_op_EX;
                exc_bus_q    <= exc_bus_EX;
                csr_bus_q    <= csr_bus_EX;
                tlb_bus_q    <= tlb_bus_EX;
            end
            if (req_out_q && ok_mine && !data_buf_v_q) begin
                data_buf_q <= data_sram_rdata;
            end
            req_out_q    <= req_out_d;
            drop_cnt_q   <= drop_cnt_d;
            data_buf_v_q <= data_buf_v_d;
        end
    end

    assign load_data = data_buf_v_q ? data_buf_q : data_sram_rdata;

    pipe_mem_load_align #(
        .LOAD_OP_W(LOAD_OP_W)
    ) u_load_align (
        .addr    (alu_result_q[1:0]),
        .load_op (load_op_q),
        .rdata   (load_data),
        .result  (load_result)
    );

    assign PC           = pc_q;
    assign rf_we_MEM    = rf_we_q;
    assign rf_waddr_MEM = rf_waddr_q;
    assign rf_wdata_MEM = is_load ? load_result : alu_result_q;
    assign exc_bus_MEM  = exc_bus_q;
    assign csr_bus_MEM  = csr_bus_q;
    assign tlb_bus_MEM  = tlb_bus_q;

endmodule

// File: tb/tb_pipe_mem.sv
// Directed bench for pipe_mem: table of single-instruction vectors plus hand-written
// buffering, flush-drop and reset sequences.
module tb_pipe_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic        from_valid;
    logic [31:0] from_pc;
    logic        to_allowin;
    logic        to_valid;
    logic        from_allowin;
    logic        flush;
    logic        rf_we_EX;
    logic [4:0]  rf_waddr_EX;
    logic [31:0] alu_result_EX;
    logic [2:0]  load_op_EX;
    logic        mem_req_EX;
    logic [37:0] exc_bus_EX;
    logic [80:0] csr_bus_EX;
    logic [3:0]  tlb_bus_EX;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [31:0] PC;
    logic        rf_we_MEM;
    logic [4:0]  rf_waddr_MEM;
    logic [31:0] rf_wdata_MEM;
    logic [37:0] exc_bus_MEM;
    logic [80:0] csr_bus_MEM;
    logic [3:0]  tlb_bus_MEM;
    logic        fwd_we;
    logic        load_pending;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_mem #(
        .LOAD_OP_W(3)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .from_valid        (from_valid),
        .from_pc           (from_pc),
        .to_allowin        (to_allowin),
        .to_valid          (to_valid),
        .from_allowin      (from_allowin),
        .flush             (flush),
        .rf_we_EX          (rf_we_EX),
        .rf_waddr_EX       (rf_waddr_EX),
        .alu_result_EX     (alu_result_EX),
        .load_op_EX        (load_op_EX),
        .mem_req_EX        (mem_req_EX),
        .exc_bus_EX        (exc_bus_EX),
        .csr_bus_EX        (csr_bus_EX),
        .tlb_bus_EX        (tlb_bus_EX),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .PC                (PC),
        .rf_we_MEM         (rf_we_MEM),
        .rf_waddr_MEM      (rf_waddr_MEM),
        .rf_wdata_MEM      (rf_wdata_MEM),
        .exc_bus_MEM       (exc_bus_MEM),
        .csr_bus_MEM       (csr_bus_MEM),
        .tlb_bus_MEM       (tlb_bus_MEM),
        .fwd_we            (fwd_we),
        .load_pending      (load_pending)
    );

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] addr;
        logic        req;
        logic [31:0] rdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance past the next rising edge, leaving time for inputs to be driven safely.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic req,
                        input logic [31:0] pc);
        from_valid    = 1'b1;
        from_pc       = pc;
        rf_we_EX      = 1'b1;
        rf_waddr_EX   = 5'd5;
        alu_result_EX = addr;
        load_op_EX    = op;
        mem_req_EX    = req;
        tick();
        from_valid = 1'b0;
        mem_req_EX = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        #1;
        chk({tag, " to_valid"}, to_valid, 1'b0);
        chk({tag, " to_allowin"}, to_allowin, 1'b1);
        chk({tag, " fwd_we"}, fwd_we, 1'b0);
        chk({tag, " load_pending"}, load_pending, 1'b0);
        chk({tag, " PC"}, PC, 32'h0);
        chk({tag, " csr_bus"}, csr_bus_MEM, 81'h0);
    endtask

    initial begin
        vecs[0] = '{"alu",     3'd0, 32'h0000_1234, 1'b0, 32'h0,         32'h0000_1234};
        vecs[1] = '{"ld_b_3",  3'd1, 32'h1000_0003, 1'b1, 32'h80FF_0000, 32'hFFFF_FF80};
        vecs[2] = '{"ld_hu_2", 3'd5, 32'h1000_0002, 1'b1, 32'h8001_0000, 32'h0000_8001};
        vecs[3] = '{"ld_h_0",  3'd2, 32'h1000_0000, 1'b1, 32'h0000_8001, 32'hFFFF_8001};
        vecs[4] = '{"ld_bu_1", 3'd4, 32'h1000_0001, 1'b1, 32'h0000_AB00, 32'h0000_00AB};
        vecs[5] = '{"ld_w_0",  3'd3, 32'h1000_0000, 1'b1, 32'h1234_5678, 32'h1234_5678};
        vecs[6] = '{"ld_b_1",  3'd1, 32'h1000_0001, 1'b1, 32'h0000_7F00, 32'h0000_007F};

        reset = 1'b1; from_valid = 0; from_pc = 0; from_allowin = 1; flush = 0;
        rf_we_EX = 0; rf_waddr_EX = 0; alu_result_EX = 0; load_op_EX = 0; mem_req_EX = 0;
        exc_bus_EX = 38'h00_1c00_0040; csr_bus_EX = 81'h1_2345_6789_abcd_ef01_2345;
        tlb_bus_EX = 4'ha; data_sram_data_ok = 0; data_sram_rdata = 0;
        tick();
        tick();
        reset = 1'b0;
        chk_reset_outputs("reset");

        for (int i = 0; i < 7; i++) begin
            send(vecs[i].op, vecs[i].addr, vecs[i].req, 32'h1c00_0000 + 32'(i) * 4);
            #1;
            if (vecs[i].req) begin
                chk({vecs[i].name, " wait to_valid"}, to_valid, 1'b0);
                chk({vecs[i].name, " wait load_pending"}, load_pending, 1'b1);
                chk({vecs[i].name, " wait to_allowin"}, to_allowin, 1'b0);
                tick();
                data_sram_data_ok = 1'b1;
                data_sram_rdata   = vecs[i].rdata;
                #1;
                chk({vecs[i].name, " load_pending"}, load_pending, 1'b0);
            end
            chk({vecs[i].name, " to_valid"}, to_valid, 1'b1);
            chk({vecs[i].name, " rf_wdata"}, rf_wdata_MEM, vecs[i].exp);
            chk({vecs[i].name, " fwd_we"}, fwd_we, 1'b1);
            chk({vecs[i].name, " PC"}, PC, 32'h1c00_0000 + 32'(i) * 4);
            chk({vecs[i].name, " buses"}, {exc_bus_MEM, csr_bus_MEM, tlb_bus_MEM},
                {38'h00_1c00_0040, 81'h1_2345_6789_abcd_ef01_2345, 4'ha});
            tick();
            data_sram_data_ok = 1'b0;
            data_sram_rdata   = 32'h0;
            #1;
            chk({vecs[i].name, " drained"}, to_valid, 1'b0);
        end

        // WB stalls when data arrives: data must be buffered and replayed later.
        from_allowin = 1'b0;
        send(3'd3, 32'h2000_0000, 1'b1, 32'h1c00_0100);
        tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hCAFE_F00D;
        #1;
        chk("buf arrive to_valid", to_valid, 1'b1);
        chk("buf arrive to_allowin", to_allowin, 1'b0);
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h1111_1111;
        tick();
        tick();
        tick();
        chk("buf hold to_valid", to_valid, 1'b1);
        chk("buf hold rf_wdata", rf_wdata_MEM, 32'hCAFE_F00D);
        chk("buf hold load_pending", load_pending, 1'b0);
        from_allowin = 1'b1;
        #1;
        chk("buf release rf_wdata", rf_wdata_MEM, 32'hCAFE_F00D);
        chk("buf release to_allowin", to_allowin, 1'b1);
        tick();
        #1;
        chk("buf done to_valid", to_valid, 1'b0);

        // Flush with a load in flight: its late response must be discarded.
        send(3'd3, 32'h3000_0000, 1'b1, 32'h1c00_0200);
        flush = 1'b1;
        #1;
        chk("flush to_valid", to_valid, 1'b0);
        tick();
        flush = 1'b0;
        send(3'd3, 32'h3000_0004, 1'b1, 32'h1c00_0204);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_DEAD;
        #1;
        chk("drop to_valid", to_valid, 1'b0);
        chk("drop load_pending", load_pending, 1'b1);
        tick();
        data_sram_data_ok = 1'b0;
        #1;
        chk("after drop pending", load_pending, 1'b1);
        tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_0007;
        #1;
        chk("second ok to_valid", to_valid, 1'b1);
        chk("second ok rf_wdata", rf_wdata_MEM, 32'h0000_0007);
        tick();
        data_sram_data_ok = 1'b0;

        // Reset mid-request: everything returns to idle and a stray response is ignored.
        send(3'd3, 32'h4000_0000, 1'b1, 32'h1c00_0300);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_outputs("midreset");
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_0BAD;
        #1;
        chk("stray to_valid", to_valid, 1'b0);
        tick();
        data_sram_data_ok = 1'b0;
        send(3'd3, 32'h4000_0008, 1'b1, 32'h1c00_0304);
        #1;
        chk("post-reset load waits", load_pending, 1'b1);
        chk("post-reset to_valid", to_valid, 1'b0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_0042;
        #1;
        chk("post-reset rf_wdata", rf_wdata_MEM, 32'h0000_0042);
        tick();
        data_sram_data_ok = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
